// File: rtl/clock_divider_pkg.sv
// Shared UART constants: divisor width,
// clamp value and the standard baud divisor.
`timescale 1ns/1ps
package clock_divider_pkg;

    localparam int DIV_W = 16;
    localparam int DIV_MIN = 2;
    localparam int BAUD_DIV_19200_12MHZ = 625;

endpackage

// File: rtl/clock_divider.sv
// Programmable integer divider: OUT_CLK with a
// period of IN cycles plus a tick at each rise.
`timescale 1ns/1ps
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    output logic             OUT_CLK,
    output logic             OUT_TICK
);

    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_div_q;
    logic [WIDTH-1:0] w_deff;
    logic [WIDTH-1:0] w_k_inc;
    logic [WIDTH-1:0] w_half;

    // Clamp IN=1 up to the minimum usable divisor
    always_comb begin
        w_deff = IN;
        if (IN == WIDTH'(1)) begin
            w_deff = WIDTH'(DIV_MIN);
        end
    end

    // k stays below div_q, so k+1 never wraps
    assign w_k_inc = r_k + WIDTH'(1);
    assign w_half  = r_div_q >> 1;

    // Phase counter, divisor latch and output flops
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_k      <= '0;
            r_div_q  <= '0;
            OUT_CLK  <= 1'b0;
            OUT_TICK <= 1'b0;
        end else if (r_k == '0) begin
            r_div_q <= w_deff;
            if (w_deff == '0) begin
                r_k      <= '0;
                OUT_CLK  <= 1'b0;
                OUT_TICK <= 1'b0;
            end else begin
                r_k      <= WIDTH'(1);
                OUT_CLK  <= 1'b1;
                OUT_TICK <= 1'b1;
            end
        end else begin
            r_k      <= (w_k_inc == r_div_q) ? '0 : w_k_inc;
            OUT_CLK  <= (r_k < w_half);
            OUT_TICK <= 1'b0;
        end
    end

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench: stimulus queues expected
// high/low counts, a monitor measures periods.
`timescale 1ns/1ps
module tb_clock_divider;
    import clock_divider_pkg::*;

    typedef struct {
        int h;
        int l;
    } exp_t;

    logic        CLK;
    logic        RST;
    logic [15:0] IN;
    logic        OUT_CLK;
    logic        OUT_TICK;

    int   n_tests;
    int   n_fail;
    exp_t q[$];

    bit   active;
    int   hc;
    int   lc;
    logic prev_clk;
    logic prev_tick;

    clock_divider #(.WIDTH(DIV_W)) dut (
        .CLK(CLK),
        .RST(RST),
        .IN(IN),
        .OUT_CLK(OUT_CLK),
        .OUT_TICK(OUT_TICK)
    );

    initial CLK = 1'b0;
    always #41.667 CLK = ~CLK;

    task automatic check(input string name,
                         input int act,
                         input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d",
                     name, act, exp);
        end
    endtask

    task automatic push(input int h, input int l);
        exp_t e;
        e.h = h;
        e.l = l;
        q.push_back(e);
    endtask

    task automatic wait_tick(input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge CLK);
            if (OUT_TICK) seen = 1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL tick_timeout: no tick in %0d cycles",
                     limit);
        end
    endtask

    task automatic run(input int d, input int h,
                       input int l, input int n);
        IN = 16'(d);
        for (int i = 0; i < n; i++) begin
            wait_tick(1000);
            push(h, l);
        end
    endtask

    // Monitor: measure each period between ticks
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            active    = 0;
            hc        = 0;
            lc        = 0;
            prev_clk  = 1'b0;
            prev_tick = 1'b0;
        end else begin
            if (OUT_TICK) begin
                check("tick_clk_high", int'(OUT_CLK), 1);
                check("tick_after_low", int'(prev_clk), 0);
                check("tick_single", int'(prev_tick), 0);
                if (active) begin
                    n_tests++;
                    if (q.size() == 0) begin
                        n_fail++;
                        $display("FAIL extra_period: got %0d/%0d, expected none",
                                 hc, lc);
                    end else begin
                        e = q.pop_front();
                        n_tests--;
                        check("period_high", hc, e.h);
                        if (e.l >= 0) check("period_low", lc, e.l);
                    end
                end
                active = 1;
                hc = 1;
                lc = 0;
            end else if (active) begin
                if (OUT_CLK) begin
                    if (lc > 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL rise_no_tick: got rise after %0d low, expected tick",
                                 lc);
                    end
                    hc++;
                end else begin
                    lc++;
                end
            end else if (OUT_CLK) begin
                n_tests++;
                n_fail++;
                $display("FAIL clk_no_tick: got OUT_CLK=1, expected 0");
            end
            prev_clk  = OUT_CLK;
            prev_tick = OUT_TICK;
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        IN  = 16'(BAUD_DIV_19200_12MHZ);
        RST = 1'b0;
        #60;
        check("rst_clk", int'(OUT_CLK), 0);
        check("rst_tick", int'(OUT_TICK), 0);
        #40;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("first_rise", int'(OUT_CLK), 1);
        check("first_tick", int'(OUT_TICK), 1);
        push(312, 313);
        run(625, 312, 313, 1);

        run(4, 2, 2, 3);
        run(5, 2, 3, 3);
        run(2, 1, 1, 3);
        run(1, 1, 1, 3);

        IN = 16'd10;
        wait_tick(1000);
        push(5, 5);
        repeat (2) @(negedge CLK);
        IN = 16'd6;
        wait_tick(1000);
        push(3, 3);
        wait_tick(1000);
        push(3, 3);

        run(8, 4, 4, 1);
        wait_tick(1000);
        push(4, -1);
        repeat (2) @(negedge CLK);
        IN = 16'd0;
        repeat (10) @(negedge CLK);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            check("idle_clk", int'(OUT_CLK), 0);
            check("idle_tick", int'(OUT_TICK), 0);
        end
        IN = 16'd8;
        @(negedge CLK);
        check("restart_clk", int'(OUT_CLK), 1);
        check("restart_tick", int'(OUT_TICK), 1);
        push(4, 4);
        wait_tick(1000);
        push(4, 4);

        IN = 16'(BAUD_DIV_19200_12MHZ);
        wait_tick(1000);
        repeat (100) @(negedge CLK);
        #10;
        RST = 1'b0;
        #1;
        check("async_rst_clk", int'(OUT_CLK), 0);
        check("async_rst_tick", int'(OUT_TICK), 0);
        repeat (3) @(negedge CLK);
        #10;
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        check("post_rst_clk", int'(OUT_CLK), 1);
        check("post_rst_tick", int'(OUT_TICK), 1);
        push(312, 313);

        IN = 16'hFFFF;
        wait_tick(1000);
        push(32767, 32768);
        IN = 16'd4;
        wait_tick(70000);
        push(2, 2);
        wait_tick(1000);

        @(negedge CLK);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed",
                 n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_divider.md
Name: clock_divider

Overview:
- Programmable integer clock divider for the UART block.
- Divides the system clock CLK by the 16-bit divisor IN and produces a near-50% duty divided clock OUT_CLK, plus a one-cycle strobe OUT_TICK at the start of each output period.
- With a 12 MHz CLK and IN = 625, OUT_CLK runs at 19200 Hz and serves as the UART baud clock.

Parameters:
- WIDTH, 16, width of divisor input IN and of the internal phase counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-low reset; 0 resets immediately, release is synchronous to CLK.
- IN  input  WIDTH  divisor D; the output period is D CLK cycles.
- OUT_CLK  output  1  divided clock, registered, glitch-free.
- OUT_TICK  output  1  registered one-CLK-cycle pulse, high during the first cycle of each OUT_CLK period (coincident with the OUT_CLK rising edge).

Behaviour:
- Reset (RST = 0, asynchronous):
  - phase counter k = 0, latched divisor div_q = 0.
  - OUT_CLK = 0, OUT_TICK = 0.
- Effective divisor: Deff = 0 if IN = 0; Deff = 2 if IN = 1; otherwise Deff = IN.
- High time: H = Deff >> 1 (floor). OUT_CLK is high for H cycles and low for Deff − H cycles.
- Each rising CLK edge with RST = 1, when k = 0 (period boundary):
  - div_q <= Deff(IN), i.e. IN is sampled only here.
  - If Deff = 0: k stays 0, OUT_CLK <= 0, OUT_TICK <= 0 (divider idle).
  - Else: k <= 1, OUT_CLK <= 1, OUT_TICK <= 1.
- Each rising CLK edge with RST = 1, when k ≠ 0:
  - k <= (k + 1 == div_q) ? 0 : k + 1.
  - OUT_CLK <= (k < div_q >> 1).
  - OUT_TICK <= 0.
- Latency: the first OUT_CLK rise and the first OUT_TICK occur on the first CLK edge after RST releases, provided IN ≥ 1.
- Divisor changes:
  - IN changes mid-period have no effect until the next boundary, so no runt or stretched pulses.
  - A new value takes effect for the whole following period.
- IN = 0:
  - Output stops at the end of the current period, with OUT_CLK low.
  - Output restarts on the first edge after IN becomes nonzero, with k = 0 at that edge.
- Odd D: the low phase is one cycle longer than the high phase (e.g. D = 625 gives 312 high / 313 low).
- Maximum D = 2^WIDTH − 1. The counter never exceeds div_q − 1, so no overflow or wrap hazard.
- Reset asserted mid-period: outputs drop to 0 immediately and the next period starts fresh after release.
- OUT_CLK must be driven directly from a flop, never from combinational logic.

Decomposition:
- Shared UART package holds:
  - DIV_W = 16.
  - DIV_MIN = 2 (clamp value used for IN = 1).
  - Baud divisor constant BAUD_DIV_19200_12MHZ = 625.
- No sub-module; the block is a single counter plus comparator.

Test Plan:
1. CLK 12 MHz (83.333 ns period), IN = 625, RST low 100 ns then high.
   - OUT_CLK rises on the first edge after release.
   - Period is 625 cycles (52.083 µs, 19200 Hz): 312 cycles high, 313 cycles low.
   - OUT_TICK is high for exactly 1 cycle per period, aligned with each OUT_CLK rise.
2. IN = 4, then IN = 5, then IN = 2.
   - IN = 4: 2 high / 2 low.
   - IN = 5: 2 high / 3 low.
   - IN = 2: alternates every cycle.
   - IN = 1 gives the same waveform as IN = 2.
3. IN changed from 10 to 6 at cycle 3 of a period.
   - The current period completes as 10 cycles (5/5).
   - The next period is 6 cycles (3/3), with no glitch.
4. IN = 0 while running at IN = 8.
   - The current period finishes and OUT_CLK stays 0 with no ticks.
   - Setting IN = 8 restarts the output with OUT_CLK rising on the next edge.
5. RST pulled low mid-high-phase, asynchronously between CLK edges, with IN = 625.
   - OUT_CLK and OUT_TICK go 0 immediately.
   - After release, a full 312/313 period restarts from the first edge.
6. IN = 65535.
   - Period is 65535 cycles: 32767 high / 32768 low.
   - Counter reaches 65534 and wraps to 0 with no overflow.
